// File: rtl/run_checker_pkg.sv
// Shared definitions for the run_checker block: controller state encoding and
// a constant-width helper for sizing counters from parameters.
package run_checker_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    RUN  = 3'd2,
    SCAN = 3'd3,
    DONE = 3'd4
  } state_t;

  // Number of bits needed to index 'value' distinct items (minimum 0).
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/run_checker_if.sv
// Scan bus between the run checker and the RAM scan port / golden ROM.
// The checker drives the word address; both memories answer one cycle later.
interface run_checker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);

  logic [ADDR_WIDTH-1:0] Scan_Address;
  logic [DATA_WIDTH-1:0] Scan_Data;
  logic [DATA_WIDTH-1:0] Gold_Data;

  modport master (
    output Scan_Address,
    input  Scan_Data,
    input  Gold_Data
  );

  modport slave (
    input  Scan_Address,
    output Scan_Data,
    output Gold_Data
  );

endinterface

// File: rtl/scan_comparator.sv
// One-stage compare pipeline for the RAM scan: tags each issued address,
// compares the returned RAM word with the golden word and tallies mismatches.
module scan_comparator #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  issue,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] issue_address,
  input  logic [DATA_WIDTH-1:0] scan_data,
  input  logic [DATA_WIDTH-1:0] gold_data,
  output logic                  mismatch,
  output logic                  last_compare,
  output logic [ADDR_WIDTH-1:0] fail_address,
  output logic [ADDR_WIDTH:0]   mismatch_count
);

  logic                  pipe_valid;
  logic [ADDR_WIDTH-1:0] pipe_address;

  assign mismatch     = pipe_valid && (scan_data != gold_data);
  assign last_compare = pipe_valid && (pipe_address == {ADDR_WIDTH{1'b1}});

  // A flush drops the address issued in the same cycle, so an early stop
  // never lets a stray compare land after the run has finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid     <= 1'b0;
      pipe_address   <= '0;
      fail_address   <= '0;
      mismatch_count <= '0;
    end else begin
      pipe_valid   <= issue && !flush;
      pipe_address <= issue_address;
      if (clear) begin
        fail_address   <= '0;
        mismatch_count <= '0;
      end else if (mismatch) begin
        if (mismatch_count == '0) begin
          fail_address <= pipe_address;
        end
        if (mismatch_count != {(ADDR_WIDTH+1){1'b1}}) begin
          mismatch_count <= mismatch_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/run_checker.sv
// Run controller for the CPU + RAM harness: holds the CPU in reset, lets it run
// until it touches the halt address or times out, then scans RAM against gold.
module run_checker
  import run_checker_pkg::*;
#(
  parameter int                DATA_WIDTH     = 32,
  parameter int                ADDR_WIDTH     = 14,
  parameter int                CPU_AW         = 32,
  parameter logic [CPU_AW-1:0] HALT_ADDR      = 32'h3ffc,
  parameter int                RESET_CYCLES   = 1,
  parameter int                TIMEOUT_CYCLES = 1000000,
  parameter int                STOP_ON_FIRST  = 0
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic [CPU_AW-1:0]     Cpu_Address,
  output logic                  Cpu_Reset,
  run_checker_if.master         scan,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Pass,
  output logic                  Timeout,
  output logic [ADDR_WIDTH-1:0] Fail_Address,
  output logic [ADDR_WIDTH:0]   Mismatch_Count
);

  localparam int CYCLE_MAX = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
  localparam int CW        = clog2(CYCLE_MAX) + 1;
  localparam logic [CW-1:0]         HOLD_LAST    = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0]         TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST    = {ADDR_WIDTH{1'b1}};

  state_t                state;
  logic [CW-1:0]         cycle_count;
  logic [ADDR_WIDTH-1:0] scan_addr;
  logic                  last_issued;
  logic                  cpu_reset_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  timeout_q;

  logic start_ok;
  logic halt_seen;
  logic issue;
  logic cmp_mismatch;
  logic cmp_last;
  logic scan_end;

  assign start_ok  = Start && ((state == IDLE) || (state == DONE));
  assign halt_seen = (Cpu_Address == HALT_ADDR);
  assign issue     = (state == SCAN) && !last_issued;
  assign scan_end  = (state == SCAN) && (cmp_last || ((STOP_ON_FIRST != 0) && cmp_mismatch));

  scan_comparator #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_compare (
    .clk            (Clock),
    .rst_n          (Reset_n),
    .clear          (start_ok),
    .issue          (issue),
    .flush          (scan_end),
    .issue_address  (scan_addr),
    .scan_data      (scan.Scan_Data),
    .gold_data      (scan.Gold_Data),
    .mismatch       (cmp_mismatch),
    .last_compare   (cmp_last),
    .fail_address   (Fail_Address),
    .mismatch_count (Mismatch_Count)
  );

  // Status outputs are registered alongside the state so they change on the
  // same edge; the cycle counter serves both the hold phase and the timeout.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cycle_count <= '0;
      scan_addr   <= '0;
      last_issued <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state       <= HOLD;
            cycle_count <= '0;
            scan_addr   <= '0;
            last_issued <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
        HOLD: begin
          if (cycle_count == HOLD_LAST) begin
            state       <= RUN;
            cpu_reset_q <= 1'b0;
            cycle_count <= '0;
          end else begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        RUN: begin
          cycle_count <= cycle_count + 1'b1;
          if (halt_seen) begin
            state       <= SCAN;
            cpu_reset_q <= 1'b1;
          end else if (cycle_count == TIMEOUT_LAST) begin
            state       <= DONE;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            timeout_q   <= 1'b1;
          end
        end
        SCAN: begin
          if (scan_end) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (issue) begin
            if (scan_addr == ADDR_LAST) begin
              last_issued <= 1'b1;
            end else begin
              scan_addr <= scan_addr + 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          cpu_reset_q <= 1'b1;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign Cpu_Reset         = cpu_reset_q;
  assign Busy              = busy_q;
  assign Done              = done_q;
  assign Timeout           = timeout_q;
  assign Pass              = done_q && !timeout_q && (Mismatch_Count == '0);
  assign scan.Scan_Address = scan_addr;

endmodule

// File: tb/tb_run_checker.sv
// Bench for run_checker: two instances (plain / stop-on-first with long hold)
// share a behavioural RAM, golden ROM and a fake CPU that halts on command.
module tb_run_checker;

   localparam int          AW    = 6;
   localparam int          DW    = 32;
   localparam int          DEPTH = 64;
   localparam int          TMO   = 100;
   localparam logic [31:0] HALT  = 32'h3ffc;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset_n;
   logic start_req;
   int   sel;
   int   halt_target;
   int   n_vec  = 0;
   int   n_miss = 0;

   logic [31:0] gold_mem [DEPTH];
   logic [31:0] ram_mem  [DEPTH];

   logic          start0, start1;
   logic [31:0]   cpu_addr0, cpu_addr1;
   logic          cpu_reset0, cpu_reset1;
   logic          busy0, busy1, done0, done1, pass0, pass1, tmo0, tmo1;
   logic [AW-1:0] fail0, fail1;
   logic [AW:0]   cnt0, cnt1;
   logic [31:0]   sdata0, sdata1, gdata0, gdata1;
   int            run_cyc0, run_cyc1;

   run_checker_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sif0 ();
   run_checker_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sif1 ();

   assign start0 = start_req && (sel == 0);
   assign start1 = start_req && (sel == 1);

   // Fake CPU: drives the halt address while held in reset (must be ignored),
   // near-miss addresses while running, and the halt address on cycle halt_target.
   function automatic logic [31:0] cpuBus(input logic rst, input int cyc, input int target);
      if (rst) return HALT;
      if (target >= 0 && cyc == target) return HALT;
      return cyc[0] ? 32'h0001_3ffc : 32'h0000_3ff8;
   endfunction

   always @(posedge clock) run_cyc0 <= cpu_reset0 ? 0 : run_cyc0 + 1;
   always @(posedge clock) run_cyc1 <= cpu_reset1 ? 0 : run_cyc1 + 1;
   assign cpu_addr0 = cpuBus(cpu_reset0, run_cyc0, halt_target);
   assign cpu_addr1 = cpuBus(cpu_reset1, run_cyc1, halt_target);

   // Registered read ports: data arrives one cycle after the address.
   always @(posedge clock) begin
      sdata0 <= ram_mem[sif0.Scan_Address];
      gdata0 <= gold_mem[sif0.Scan_Address];
      sdata1 <= ram_mem[sif1.Scan_Address];
      gdata1 <= gold_mem[sif1.Scan_Address];
   end
   assign sif0.Scan_Data = sdata0;
   assign sif0.Gold_Data = gdata0;
   assign sif1.Scan_Data = sdata1;
   assign sif1.Gold_Data = gdata1;

   run_checker #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CPU_AW(32), .HALT_ADDR(HALT),
      .RESET_CYCLES(1), .TIMEOUT_CYCLES(TMO), .STOP_ON_FIRST(0)
   ) dut0 (
      .Clock(clock), .Reset_n(reset_n), .Start(start0), .Cpu_Address(cpu_addr0),
      .Cpu_Reset(cpu_reset0), .scan(sif0), .Busy(busy0), .Done(done0), .Pass(pass0),
      .Timeout(tmo0), .Fail_Address(fail0), .Mismatch_Count(cnt0)
   );

   run_checker #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CPU_AW(32), .HALT_ADDR(HALT),
      .RESET_CYCLES(4), .TIMEOUT_CYCLES(TMO), .STOP_ON_FIRST(1)
   ) dut1 (
      .Clock(clock), .Reset_n(reset_n), .Start(start1), .Cpu_Address(cpu_addr1),
      .Cpu_Reset(cpu_reset1), .scan(sif1), .Busy(busy1), .Done(done1), .Pass(pass1),
      .Timeout(tmo1), .Fail_Address(fail1), .Mismatch_Count(cnt1)
   );

   logic          s_cpu_reset, s_busy, s_done, s_pass, s_tmo;
   logic [AW-1:0] s_fail, s_addr;
   logic [AW:0]   s_cnt;
   assign s_cpu_reset = sel == 1 ? cpu_reset1 : cpu_reset0;
   assign s_busy      = sel == 1 ? busy1 : busy0;
   assign s_done      = sel == 1 ? done1 : done0;
   assign s_pass      = sel == 1 ? pass1 : pass0;
   assign s_tmo       = sel == 1 ? tmo1 : tmo0;
   assign s_fail      = sel == 1 ? fail1 : fail0;
   assign s_cnt       = sel == 1 ? cnt1 : cnt0;
   assign s_addr      = sel == 1 ? sif1.Scan_Address : sif0.Scan_Address;

   typedef struct {
      int dut;
      int halt;
      int bad_a;
      int bad_b;
      int glitch;
      int exp_pass;
      int exp_timeout;
      int exp_count;
      int exp_fail;
      int exp_cycles;
   } vec_t;

   // Compare one observed value with its expected value and tally the result.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Load RAM with the golden image, corrupting up to two chosen words.
   task automatic prepareMemory(input int bad_a, input int bad_b);
      for (int i = 0; i < DEPTH; i++) ram_mem[i] = gold_mem[i];
      if (bad_a >= 0) ram_mem[bad_a] = gold_mem[bad_a] ^ 32'h0000_0100;
      if (bad_b >= 0) ram_mem[bad_b] = ~gold_mem[bad_b];
   endtask

   // Reference outcome of a run, derived directly from the memory contents.
   task automatic modelRun(input int d, input int halt, output int pass, output int tmo,
                           output int count, output int fail, output int cycles);
      int r, n, first;
      r = (d == 1) ? 4 : 1;
      n = 0;
      first = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (ram_mem[i] != gold_mem[i]) begin
            if (first < 0) first = i;
            n++;
         end
      end
      tmo = (halt < 0 || halt > TMO - 1) ? 1 : 0;
      if (tmo == 1) begin
         count  = 0;
         fail   = 0;
         cycles = r + TMO;
      end else begin
         count  = (d == 1 && n > 0) ? 1 : n;
         fail   = (first < 0) ? 0 : first;
         cycles = r + halt + 1 + ((d == 1 && n > 0) ? first + 2 : DEPTH + 1);
      end
      pass = (tmo == 0 && count == 0) ? 1 : 0;
   endtask

   // Start one run on DUT d, optionally pulse Start while busy, wait for Done
   // and check timing and results.
   task automatic applyStimulus(input int d, input int halt, input int glitch, input int exp_pass,
                                input int exp_tmo, input int exp_count, input int exp_fail,
                                input int exp_cycles);
      int n, release_at;
      sel = d;
      halt_target = halt;
      @(negedge clock);
      start_req = 1'b1;
      @(negedge clock);
      start_req = 1'b0;
      checkOutput("busy_after_start", {63'd0, s_busy}, 64'd1);
      n = 0;
      release_at = -1;
      while (n < 1000) begin
         @(negedge clock);
         n++;
         if (release_at < 0 && s_cpu_reset == 1'b0) release_at = n;
         if (s_done) break;
         start_req = (glitch != 0) && (n % 5 == 0);
      end
      start_req = 1'b0;
      checkOutput("done_within_budget", {63'd0, s_done}, 64'd1);
      checkOutput("cycles_to_done", 64'(n), 64'(exp_cycles));
      checkOutput("cpu_reset_release", 64'(release_at), 64'((d == 1) ? 4 : 1));
      checkOutput("pass", {63'd0, s_pass}, 64'(exp_pass));
      checkOutput("timeout", {63'd0, s_tmo}, 64'(exp_tmo));
      checkOutput("mismatch_count", 64'(s_cnt), 64'(exp_count));
      checkOutput("fail_address", 64'(s_fail), 64'(exp_fail));
      checkOutput("busy_at_done", {63'd0, s_busy}, 64'd0);
      if (exp_tmo != 0) checkOutput("scan_address_timeout", 64'(s_addr), 64'd0);
      repeat (3) @(negedge clock);
      checkOutput("done_held", {63'd0, s_done}, 64'd1);
      checkOutput("count_held", 64'(s_cnt), 64'(exp_count));
      checkOutput("cpu_reset_in_done", {63'd0, s_cpu_reset}, 64'd1);
   endtask

   vec_t vecs [9];

   initial begin
      int p, t, c, f, cy, d, h;
      vecs[0] = '{0,  20,   -1,   -1, 0, 1, 0, 0, 0,    87};
      vecs[1] = '{0,   5, 'h10, 'h30, 0, 0, 0, 2, 'h10, 72};
      vecs[2] = '{1,   5, 'h10, 'h30, 1, 0, 0, 1, 'h10, 28};
      vecs[3] = '{0,  -1,   -1,   -1, 1, 0, 1, 0, 0,   101};
      vecs[4] = '{0,  99,   -1,   -1, 0, 1, 0, 0, 0,   166};
      vecs[5] = '{1,  98,   -1,   -1, 1, 1, 0, 0, 0,   168};
      vecs[6] = '{1, 100,   -1,   -1, 0, 0, 1, 0, 0,   104};
      vecs[7] = '{0,   0,    0,   63, 1, 0, 0, 2, 0,    67};
      vecs[8] = '{1,   0,   63,   -1, 0, 0, 0, 1, 63,   70};

      for (int i = 0; i < DEPTH; i++) gold_mem[i] = $urandom;
      prepareMemory(-1, -1);
      reset_n     = 1'b0;
      start_req   = 1'b0;
      sel         = 0;
      halt_target = -1;
      #12;
      for (int k = 0; k < 2; k++) begin
         sel = k;
         #1;
         checkOutput("reset_cpu_reset", {63'd0, s_cpu_reset}, 64'd1);
         checkOutput("reset_busy_done", {62'd0, s_busy, s_done}, 64'd0);
         checkOutput("reset_pass_timeout", {62'd0, s_pass, s_tmo}, 64'd0);
         checkOutput("reset_results", {s_addr, s_fail, s_cnt}, 64'd0);
      end
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         prepareMemory(vecs[i].bad_a, vecs[i].bad_b);
         applyStimulus(vecs[i].dut, vecs[i].halt, vecs[i].glitch, vecs[i].exp_pass,
                       vecs[i].exp_timeout, vecs[i].exp_count, vecs[i].exp_fail,
                       vecs[i].exp_cycles);
      end

      // Reset asserted in the middle of a scan that has already found a mismatch.
      prepareMemory('h10, -1);
      sel = 0;
      halt_target = 5;
      @(negedge clock);
      start_req = 1'b1;
      @(negedge clock);
      start_req = 1'b0;
      repeat (27) @(negedge clock);
      checkOutput("midscan_busy", {63'd0, s_busy}, 64'd1);
      checkOutput("midscan_count", 64'(s_cnt), 64'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("async_cpu_reset", {63'd0, s_cpu_reset}, 64'd1);
      checkOutput("async_busy_done", {62'd0, s_busy, s_done}, 64'd0);
      checkOutput("async_results", {s_addr, s_fail, s_cnt}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      prepareMemory(-1, -1);
      applyStimulus(0, 30, 0, 1, 0, 0, 0, 1 + 31 + DEPTH + 1);

      // Randomised runs scored against the reference model.
      for (int r = 0; r < 8; r++) begin
         prepareMemory(-1, -1);
         for (int k = 0; k < 3; k++) begin
            if ($urandom_range(0, 1) == 1) begin
               int a;
               a = $urandom_range(0, DEPTH - 1);
               ram_mem[a] = ram_mem[a] ^ (32'h1 << $urandom_range(0, 31));
            end
         end
         d = $urandom_range(0, 1);
         h = $urandom_range(0, 110);
         if (h > 105) h = -1;
         modelRun(d, h, p, t, c, f, cy);
         applyStimulus(d, h, $urandom_range(0, 1), p, t, c, f, cy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
